// File: rtl/mealy_path_driver_if.sv
// Target-request handshake between control logic and mealy_path_driver.
`timescale 1ns/1ps
interface mealy_path_driver_if #(
    parameter int ST_W = 3
);
    logic            req_valid_i;
    logic [ST_W-1:0] req_state_i;
    logic            req_ready_o;

    modport master (output req_valid_i, output req_state_i, input req_ready_o);
    modport slave  (input req_valid_i, input req_state_i, output req_ready_o);
endinterface

// File: rtl/mealy_path_driver.sv
// Steers a five-state Mealy FSM to a requested state along the shortest symbol path,
// while checking the FSM's output against an internal model of it.
`timescale 1ns/1ps
module mealy_path_driver #(
    parameter int ST_W     = 3,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    mealy_path_driver_if.slave   req,
    output logic [1:0]           sym_o,
    input  logic                 fsm_out_i,
    output logic                 done_o,
    output logic [1:0]           hops_o,
    output logic                 bad_req_o,
    output logic                 err_o,
    output logic [ST_W-1:0]      model_state_o
);
    localparam logic [ST_W-1:0] ST0 = ST_W'(0);
    localparam logic [ST_W-1:0] ST1 = ST_W'(1);
    localparam logic [ST_W-1:0] ST2 = ST_W'(2);
    localparam logic [ST_W-1:0] ST3 = ST_W'(3);
    localparam logic [ST_W-1:0] ST4 = ST_W'(4);

    typedef enum logic {IDLE, MOVE} state_t;

    function automatic logic [ST_W-1:0] f_next(input logic [ST_W-1:0] st, input logic [1:0] sym);
        f_next = ST0;
        case (st)
            ST0: case (sym)
                2'b00:   f_next = ST0;
                2'b01:   f_next = ST4;
                2'b10:   f_next = ST1;
                default: f_next = ST2;
            endcase
            ST1: f_next = (sym == 2'b00) ? ST0 : ((sym == 2'b10) ? ST2 : ST1);
            ST2: f_next = sym[1] ? ST3 : ST1;
            ST3: f_next = sym[0] ? ST4 : ST3;
            ST4: f_next = (sym == 2'b11) ? ST4 : ST0;
            default: f_next = ST0;
        endcase
    endfunction

    function automatic logic f_mealy(input logic [ST_W-1:0] st, input logic [1:0] sym);
        f_mealy = 1'b0;
        case (st)
            ST0:     f_mealy = |sym;
            ST2:     f_mealy = sym[1];
            ST3:     f_mealy = 1'b1;
            ST4:     f_mealy = sym[1];
            default: f_mealy = 1'b0;
        endcase
    endfunction

    // st2 has no self-loop, so its hold symbol drifts the model to st1.
    function automatic logic [1:0] f_hold(input logic [ST_W-1:0] st);
        f_hold = 2'b00;
        if (st == ST1) f_hold = 2'b01;
        if (st == ST4) f_hold = 2'b11;
    endfunction

    function automatic logic [1:0] f_hop(input logic [ST_W-1:0] from, input logic [ST_W-1:0] to);
        f_hop = 2'b00;
        case (from)
            ST0: case (to)
                ST1:      f_hop = 2'b10;
                ST2, ST3: f_hop = 2'b11;
                ST4:      f_hop = 2'b01;
                default:  f_hop = 2'b00;
            endcase
            ST1:     f_hop = (to == ST2 || to == ST3) ? 2'b10 : 2'b00;
            ST2:     f_hop = (to == ST3 || to == ST4) ? 2'b10 : 2'b00;
            ST3:     f_hop = 2'b01;
            default: f_hop = 2'b00;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_state_nx;
    logic [ST_W-1:0] r_model;
    logic [ST_W-1:0] r_target;
    logic [1:0]      r_hops;
    logic            r_bad;
    logic            r_err;
    logic [1:0]      w_sym;
    logic            w_done;
    logic            w_accept;
    logic            w_bad;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nx = r_state;
        w_sym      = f_hold(r_model);
        w_done     = 1'b0;
        w_accept   = 1'b0;
        w_bad      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req.req_valid_i) begin
                    if (req.req_state_i <= ST4) begin
                        w_accept   = 1'b1;
                        w_state_nx = MOVE;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            MOVE: begin
                if (r_model != r_target) begin
                    w_sym = f_hop(r_model, r_target);
                end else begin
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            r_state  <= IDLE;
            r_model  <= ST0;
            r_target <= ST0;
            r_hops   <= 2'd0;
            r_bad    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_model <= f_next(r_model, w_sym);
            r_bad   <= w_bad;
            if (w_accept) begin
                r_target <= req.req_state_i;
                r_hops   <= 2'd0;
            end else if (r_state == MOVE && !w_done) begin
                r_hops <= r_hops + 2'd1;
            end
            if (CHECK_EN && (fsm_out_i != f_mealy(r_model, w_sym))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req.req_ready_o = (r_state == IDLE);
    assign sym_o           = w_sym;
    // A reset landing on the arrival cycle abandons the request without a done pulse.
    assign done_o          = w_done & ~reset_i;
    assign hops_o          = r_hops;
    assign bad_req_o       = r_bad;
    assign err_o           = r_err;
    assign model_state_o   = r_model;
endmodule

// File: tb/tb_mealy_path_driver.sv
// Directed bench: a behavioural five-state Mealy FSM is driven by the DUT while
// per-cycle outputs are compared against hand-computed vectors.
`timescale 1ns/1ps
module tb_mealy_path_driver;
    logic       clk = 1'b0;
    logic       reset_i;
    logic [1:0] sym;
    logic       fsm_out;
    logic       done;
    logic [1:0] hops;
    logic       bad;
    logic       err;
    logic [2:0] model;
    logic       flip;
    logic [2:0] r_fsm;
    int         n_vec  = 0;
    int         n_miss = 0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  st;
        logic        flip;
        logic        rst;
        logic [10:0] want;
    } step_t;

    mealy_path_driver_if #(.ST_W(3)) req_if ();

    mealy_path_driver #(.ST_W(3), .CHECK_EN(1'b1)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req           (req_if),
        .sym_o         (sym),
        .fsm_out_i     (fsm_out),
        .done_o        (done),
        .hops_o        (hops),
        .bad_req_o     (bad),
        .err_o         (err),
        .model_state_o (model)
    );

    always #5 clk = ~clk;

    // Stand-in for the driven five_state_mealy FSM, reset together with the DUT.
    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic [1:0] y);
        case (s)
            3'd0:    return (y == 2'b00) ? 3'd0 : (y == 2'b01) ? 3'd4 : (y == 2'b10) ? 3'd1 : 3'd2;
            3'd1:    return (y == 2'b00) ? 3'd0 : (y == 2'b10) ? 3'd2 : 3'd1;
            3'd2:    return y[1] ? 3'd3 : 3'd1;
            3'd3:    return y[0] ? 3'd4 : 3'd3;
            3'd4:    return (y == 2'b11) ? 3'd4 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic fsm_mealy(input logic [2:0] s, input logic [1:0] y);
        case (s)
            3'd0:    return (y != 2'b00);
            3'd2:    return y[1];
            3'd3:    return 1'b1;
            3'd4:    return y[1];
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_i) r_fsm <= 3'd0;
        else         r_fsm <= fsm_next(r_fsm, sym);
    end

    assign fsm_out = fsm_mealy(r_fsm, sym) ^ flip;

    function automatic logic [10:0] obs();
        return {req_if.req_ready_o, sym, done, hops, bad, err, model};
    endfunction

    function automatic step_t mk(input logic v, input logic [2:0] st, input logic f, input logic r,
                                 input logic rdy, input logic [1:0] sy, input logic dn,
                                 input logic [1:0] hp, input logic bd, input logic er,
                                 input logic [2:0] md);
        step_t t;
        t.valid = v;
        t.st    = st;
        t.flip  = f;
        t.rst   = r;
        t.want  = {rdy, sy, dn, hp, bd, er, md};
        return t;
    endfunction

    task automatic test_reset();
        step_t s[$];
        reset_i = 1'b1;
        req_if.req_valid_i = 1'b0;
        req_if.req_state_i = 3'd0;
        flip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL reset step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_one_hop();
        step_t s[$];
        s.push_back(mk(1, 2, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 2));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 1, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL one_hop step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_return_home(input logic [1:0] prev_hops);
        step_t s[$];
        s.push_back(mk(1, 0, 0, 0, 1, 2'b01, 0, prev_hops, 0, 0, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL return_home step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_two_hop();
        step_t s[$];
        s.push_back(mk(1, 3, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0, 2));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 2, 0, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 2, 0, 0, 3));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL two_hop step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_three_hop();
        step_t s[$];
        s.push_back(mk(1, 2, 0, 0, 1, 2'b00, 0, 2, 0, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 2, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 3, 0, 0, 2));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 3, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL three_hop step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_hop();
        step_t s[$];
        s.push_back(mk(1, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL zero_hop step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    // Valid stays high through MOVE: ignored there, accepted on the next IDLE cycle.
    task automatic test_back_to_back();
        step_t s[$];
        s.push_back(mk(1, 4, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 4, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 2'b11, 1, 1, 0, 0, 4));
        s.push_back(mk(1, 1, 0, 0, 1, 2'b11, 0, 1, 0, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b01, 1, 2, 0, 0, 1));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 2, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL back_to_back step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bad_req();
        step_t s[$];
        s.push_back(mk(1, 5, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        s.push_back(mk(1, 7, 0, 0, 1, 2'b00, 0, 1, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 1, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL bad_req step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mismatch();
        step_t s[$];
        s.push_back(mk(1, 3, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0, 2));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 2, 0, 0, 3));
        s.push_back(mk(0, 0, 1, 0, 1, 2'b00, 0, 2, 0, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 2, 0, 1, 3));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 2, 0, 1, 3));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL mismatch step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_move();
        step_t s[$];
        s.push_back(mk(1, 0, 0, 0, 1, 2'b00, 0, 2, 0, 1, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 2, 0, 1, 0));
        s.push_back(mk(1, 3, 0, 0, 1, 2'b00, 0, 2, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 2'b10, 0, 1, 0, 1, 2));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            req_if.req_valid_i = s[i].valid; req_if.req_state_i = s[i].st; flip = s[i].flip; reset_i = s[i].rst;
            #1;
            n_vec++;
            if (obs() !== s[i].want) begin
                n_miss++;
                $display("FAIL reset_mid_move step %0d: observed %b required %b (ready,sym,done,hops,bad,err,model)", i, obs(), s[i].want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_one_hop();
        test_return_home(2'd1);
        test_two_hop();
        test_three_hop();
        test_return_home(2'd3);
        test_zero_hop();
        test_back_to_back();
        test_return_home(2'd2);
        test_bad_req();
        test_mismatch();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mealy_path_driver.md
Name: mealy_path_driver

Overview:
- Symbol-stream generator that drives five_state_mealy-style FSMs (2-bit symbol in, 1-bit Mealy output).
- Accepts a target-state request over a valid/ready handshake.
- Keeps an internal model of the driven FSM and emits, one per cycle, the shortest symbol sequence that steers the FSM to the target.
- Checks the FSM's 1-bit output against the modelled Mealy output every cycle.
- Sits between test/control logic and the FSM; shares its clock.

Parameters:
- ST_W, 3, state encoding width (states 0..4 are legal).
- CHECK_EN, 1, when 1 compare fsm_out_i against the model; when 0, err_o stays 0.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  target request valid.
- req_state_i  input  ST_W  requested target state.
- req_ready_o  output  1  high in IDLE only.
- sym_o  output  2  symbol to the FSM data_i.
- fsm_out_i  input  1  FSM data_out, same-cycle Mealy output.
- done_o  output  1  one-cycle pulse: model reached target.
- hops_o  output  2  symbols issued for the last request, valid with done_o and held until the next accept.
- bad_req_o  output  1  one-cycle pulse: rejected target (>4).
- err_o  output  1  sticky output-mismatch flag.
- model_state_o  output  ST_W  current modelled FSM state.

Behaviour:
- Driven FSM transition model, written as state: symbol -> next state. This is the normative protocol table:
  - st0: 00->0, 01->4, 10->1, 11->2.
  - st1: 00->0, 10->2, 01/11->1.
  - st2: 0x->1, 1x->3.
  - st3: x1->4, x0->3.
  - st4: 11->4, others->0.
- Mealy output model:
  - st0: 0 if sym==00, else 1.
  - st1: 0.
  - st2: sym[1].
  - st3: 1.
  - st4: sym[1].
- Next-hop table, written as from->to: symbol:
  - From st0: 1:10, 2:11, 3:11, 4:01.
  - From st1: 0:00, 2:10, 3:10, 4:00.
  - From st2: 0:00, 1:00, 3:10, 4:10.
  - From st3: any other state:01.
  - From st4: any other state:00.
- Hold symbol (self-loop):
  - st0:00, st1:01, st3:00, st4:11.
  - st2 has no self-loop; its hold symbol is 00, and the model moves to st1.
- Reset (cycle where reset_i=1 at the edge): FSM=IDLE, model=0, target=0, sym_o=00 (combinational from model), done_o=0, hops_o=0, bad_req_o=0, err_o=0. The driven FSM must be reset in the same cycle.
- Reset mid-MOVE abandons the request; no done_o is issued.
- Control FSM states: IDLE, MOVE.
  - IDLE: req_ready_o=1 and sym_o=hold(model).
  - IDLE with req_valid_i=1 and req_state_i<=4: latch target, clear the hop count, go to MOVE next cycle.
  - IDLE with req_valid_i=1 and req_state_i>4: pulse bad_req_o next cycle, stay IDLE, model unaffected except hold behaviour.
  - MOVE with model!=target: sym_o=hop(model,target); on the edge model<=next(model,sym_o) and hops+1.
  - MOVE with model==target: sym_o=hold(model), done_o=1, hops_o=count, return to IDLE on the edge.
  - req_ready_o=0 throughout MOVE.
- Latency: target equal to the current model gives done_o 1 cycle after accept with hops_o=0. The longest route is 3 hops (for example 3->2 or 4->3), giving done_o 4 cycles after accept.
- The 2-bit hop counter cannot overflow; 3 is the maximum.
- The model always updates from sym_o every cycle in both states, including the st2 hold move to st1.
- Check (CHECK_EN=1): every cycle after reset, if fsm_out_i != mealy(model,sym_o), set err_o. err_o clears only on reset.
- model_state_o is registered.

Test Plan:
- Reset, then request 2 -> sym_o 11 in the first MOVE cycle; done_o 2 cycles after accept; hops_o=1; model_state_o=2; one cycle later idle hold moves the model to 1.
- From 0, request 3 -> sym_o 11 then 10; done_o with hops_o=2; model=3.
- From 3, request 2 -> symbols 01, 00, 11 (3->4->0->2); hops_o=3; model=2 at done.
- Request 0 while model=0 -> done_o 1 cycle after accept, hops_o=0, sym_o 00 throughout.
- Request 5 -> bad_req_o pulse, req_ready_o stays 1, no done_o, model unchanged. Then force fsm_out_i opposite to the model in st3 -> err_o=1, held until reset.
- Assert reset_i during MOVE toward 3 -> next cycle IDLE, model 0, sym_o 00, no done_o, err_o 0.
